// File: rtl/crc_req_arbiter_if.sv
// Request/response bundle between client blocks and crc_req_arbiter.
// The master modport is the client side and the slave modport is the arbiter side.
interface crc_req_arbiter_if #(
    parameter int NREQ        = 4,
    parameter int DWIDTH      = 16,
    parameter int CRC_GPW_MAX = 8,
    parameter int IDW         = 2
);
    logic [NREQ-1:0]             reqValid;
    logic [NREQ*DWIDTH-1:0]      reqData;
    logic [NREQ*CRC_GPW_MAX-1:0] reqPoly;
    logic [NREQ-1:0]             reqReady;
    logic                        rspValid;
    logic                        rspReady;
    logic [IDW-1:0]              rspId;
    logic [CRC_GPW_MAX-1:0]      rspCrc;
    logic                        rspErr;

    modport master (
        output reqValid, reqData, reqPoly, rspReady,
        input  reqReady, rspValid, rspId, rspCrc, rspErr
    );

    modport slave (
        input  reqValid, reqData, reqPoly, rspReady,
        output reqReady, rspValid, rspId, rspCrc, rspErr
    );
endinterface

// File: rtl/crc_req_arbiter.sv
// Round-robin front end sharing one crcParallel engine among NREQ clients.
// Optional engine watchdog is enabled by defining CRC_REQ_ARB_TIMEOUT_EN.
module crc_req_arbiter #(
    parameter int NREQ        = 4,
    parameter int DWIDTH      = 16,
    parameter int CRC_GPW_MAX = 8,
    parameter int IDW         = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rstN,
    crc_req_arbiter_if.slave       rq,
    output logic                   ctrlEn,
    output logic [DWIDTH-1:0]      dataIn,
    output logic [CRC_GPW_MAX-1:0] GenPoly,
    input  logic [CRC_GPW_MAX-1:0] crcSeq,
    input  logic                   crcReady,
    output logic                   busy
);

    if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || TIMEOUT_CYC < 2) begin : gBadCfg
        $error("crc_req_arbiter: illegal parameter set");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t                 state;
    state_t                 stateNxt;
    logic [IDW-1:0]         rrPtr;
    logic [IDW-1:0]         idReg;
    logic [IDW-1:0]         winIdx;
    logic [IDW-1:0]         candIdx;
    logic                   winAny;
    logic                   grant;
    logic                   toHit;
    int                     cand;
    logic [CRC_GPW_MAX-1:0] crcReg;

    logic [DWIDTH-1:0]      reqDataArr [NREQ];
    logic [CRC_GPW_MAX-1:0] reqPolyArr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : gUnpack
        assign reqDataArr[i] = rq.reqData[i*DWIDTH +: DWIDTH];
        assign reqPolyArr[i] = rq.reqPoly[i*CRC_GPW_MAX +: CRC_GPW_MAX];
    end

    // Search starts just after the last winner and wraps, so every requester is reached within NREQ rounds.
    always_comb begin
        winAny  = 1'b0;
        winIdx  = '0;
        cand    = 0;
        candIdx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand    = (int'(rrPtr) + k) % NREQ;
            candIdx = IDW'(cand);
            if (!winAny && rq.reqValid[candIdx]) begin
                winAny = 1'b1;
                winIdx = candIdx;
            end
        end
    end

    // rstN gates the accept so no client sees a transfer while the block is held in reset.
    assign grant = (state == IDLE) && winAny && rstN;

    always_comb begin
        rq.reqReady = '0;
        if (grant) begin
            rq.reqReady[winIdx] = 1'b1;
        end
    end

`ifdef CRC_REQ_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] toCnt;
    logic          errReg;
    logic          waiting;

    assign waiting = (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign toHit   = waiting && (toCnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            toCnt <= '0;
        end else if (state == ISSUE) begin
            toCnt <= '0;
        end else if (waiting && !toHit) begin
            toCnt <= toCnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            errReg <= 1'b0;
        end else if (state == WAIT_DONE && crcReady) begin
            errReg <= 1'b0;
        end else if (toHit) begin
            errReg <= 1'b1;
        end
    end

    assign rq.rspErr = errReg;
`else
    assign toHit     = 1'b0;
    assign rq.rspErr = 1'b0;
`endif

    always_comb begin
        stateNxt = state;
        unique case (state)
            IDLE:      if (winAny) stateNxt = ISSUE;
            ISSUE:     stateNxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!crcReady) begin
                    stateNxt = WAIT_DONE;
                end else if (toHit) begin
                    stateNxt = RESP;
                end
            end
            WAIT_DONE: if (crcReady || toHit) stateNxt = RESP;
            RESP:      if (rq.rspReady) stateNxt = IDLE;
            default:   stateNxt = IDLE;
        endcase
    end

    // Engine operands only move on a grant, so they are frozen for the whole engine run.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state   <= IDLE;
            rrPtr   <= IDW'(NREQ - 1);
            idReg   <= '0;
            dataIn  <= '0;
            GenPoly <= '0;
            crcReg  <= '0;
        end else begin
            state <= stateNxt;
            if (grant) begin
                rrPtr   <= winIdx;
                idReg   <= winIdx;
                dataIn  <= reqDataArr[winIdx];
                GenPoly <= reqPolyArr[winIdx];
            end
            if (state == WAIT_DONE && crcReady) begin
                crcReg <= crcSeq;
            end else if (toHit) begin
                crcReg <= '0;
            end
        end
    end

    assign ctrlEn      = (state == ISSUE);
    assign busy        = (state != IDLE);
    assign rq.rspValid = (state == RESP);
    assign rq.rspId    = idReg;
    assign rq.rspCrc   = crcReg;

endmodule

// File: tb/tb_crc_req_arbiter.sv
// Randomized scoreboard bench for crc_req_arbiter with a behavioural crcParallel stub.
// Define CRC_REQ_ARB_TIMEOUT_EN to also exercise the engine watchdog.
module tb_crc_req_arbiter;
    localparam int NREQ        = 4;
    localparam int DWIDTH      = 16;
    localparam int CRC_GPW_MAX = 8;
    localparam int IDW         = 2;
    localparam int TIMEOUT_CYC = 64;

    typedef struct {
        int                     id;
        logic [CRC_GPW_MAX-1:0] crc;
        logic                   err;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rstN;
    logic                   ctrlEn;
    logic [DWIDTH-1:0]      dataIn;
    logic [CRC_GPW_MAX-1:0] GenPoly;
    logic [CRC_GPW_MAX-1:0] crcSeq;
    logic                   crcReady;
    logic                   busy;
    logic                   tbHang = 1'b0;
    logic                   keepValid;
    int                     engCnt;
    int                     nChecks = 0;
    int                     nFail = 0;

    exp_t expQ[$];
    int   orderQ[$];

    crc_req_arbiter_if #(.NREQ(NREQ), .DWIDTH(DWIDTH), .CRC_GPW_MAX(CRC_GPW_MAX), .IDW(IDW)) rq ();

    crc_req_arbiter #(
        .NREQ(NREQ), .DWIDTH(DWIDTH), .CRC_GPW_MAX(CRC_GPW_MAX), .IDW(IDW), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rstN(rstN), .rq(rq), .ctrlEn(ctrlEn), .dataIn(dataIn), .GenPoly(GenPoly),
        .crcSeq(crcSeq), .crcReady(crcReady), .busy(busy)
    );

    always #5 clk = ~clk;

    // MSB-first polynomial long division, zero initial value, no reflection.
    function automatic logic [CRC_GPW_MAX-1:0] crcRef(input logic [DWIDTH-1:0] d, input logic [CRC_GPW_MAX-1:0] p);
        logic [DWIDTH+CRC_GPW_MAX-1:0] r;
        logic [DWIDTH+CRC_GPW_MAX-1:0] g;
        r = {d, {CRC_GPW_MAX{1'b0}}};
        g = {{(DWIDTH-1){1'b0}}, 1'b1, p};
        for (int i = DWIDTH + CRC_GPW_MAX - 1; i >= CRC_GPW_MAX; i--) begin
            if (r[i]) r = r ^ (g << (i - CRC_GPW_MAX));
        end
        return r[CRC_GPW_MAX-1:0];
    endfunction

    function automatic int rrPick(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Engine stub: busy for a random spell after each start, garbage on crcSeq until done.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            crcReady <= 1'b1;
            engCnt   <= 0;
            crcSeq   <= '0;
        end else if (ctrlEn) begin
            crcReady <= 1'b0;
            engCnt   <= int'($urandom_range(3, 12));
            crcSeq   <= CRC_GPW_MAX'($urandom);
        end else if (engCnt > 1) begin
            engCnt <= engCnt - 1;
        end else if (engCnt == 1 && !tbHang) begin
            engCnt   <= 0;
            crcReady <= 1'b1;
            crcSeq   <= crcRef(dataIn, GenPoly);
        end
    end

    // Reference model: predicts grants, engine starts and responses from the arbitration rules.
    logic                   mIdle;
    logic                   mHave;
    logic                   pendCtrl;
    int                     mLast;
    int                     mW;
    logic [NREQ-1:0]        mRdy;
    logic [DWIDTH-1:0]      mD;
    logic [CRC_GPW_MAX-1:0] mP;

    always @(negedge clk) begin
        if (!rstN) begin
            mIdle    = 1'b1;
            mHave    = 1'b0;
            pendCtrl = 1'b0;
            mLast    = NREQ - 1;
            expQ.delete();
        end else begin
            mW   = mIdle ? rrPick(mLast, rq.reqValid) : -1;
            mRdy = (mW >= 0) ? (NREQ'(1) << mW) : '0;
            chk("busy", 32'(busy), 32'(!mIdle));
            if (mIdle || rq.reqReady != '0) chk("reqReady", 32'(rq.reqReady), 32'(mRdy));
            if (pendCtrl || ctrlEn) chk("ctrlEn", 32'(ctrlEn), 32'(pendCtrl));
            if (mHave) chk("engineOperands", 32'({dataIn, GenPoly}), 32'({mD, mP}));
            pendCtrl = 1'b0;
            if (mW >= 0) begin
                mD = rq.reqData[mW*DWIDTH +: DWIDTH];
                mP = rq.reqPoly[mW*CRC_GPW_MAX +: CRC_GPW_MAX];
                expQ.push_back('{id: mW, crc: (tbHang ? '0 : crcRef(mD, mP)), err: tbHang});
                mLast    = mW;
                mIdle    = 1'b0;
                mHave    = 1'b1;
                pendCtrl = 1'b1;
            end
            if (rq.rspValid && rq.rspReady) mIdle = 1'b1;
        end
    end

    // Response monitor: pops the scoreboard on every response handshake.
    logic                   pV;
    logic                   pT;
    logic [IDW-1:0]         pId;
    logic [CRC_GPW_MAX-1:0] pCrc;
    logic                   pErr;
    exp_t                   sb;

    always @(negedge clk) begin
        if (!rstN) begin
            pV = 1'b0;
            pT = 1'b0;
        end else begin
            if (pV && !pT) begin
                chk("rspHeld", 32'(rq.rspValid), 32'(1));
                chk("rspStable", 32'({rq.rspId, rq.rspCrc, rq.rspErr}), 32'({pId, pCrc, pErr}));
            end
            if (rq.rspValid && rq.rspReady) begin
                if (expQ.size() == 0) begin
                    chk("rspSpurious", 32'(rq.rspValid), 32'(0));
                end else begin
                    sb = expQ.pop_front();
                    chk("rspId", 32'(rq.rspId), 32'(sb.id));
                    chk("rspCrc", 32'(rq.rspCrc), 32'(sb.crc));
                    chk("rspErr", 32'(rq.rspErr), 32'(sb.err));
                end
            end
            pV   = rq.rspValid;
            pT   = rq.rspValid && rq.rspReady;
            pId  = rq.rspId;
            pCrc = rq.rspCrc;
            pErr = rq.rspErr;
        end
    end

    task automatic step();
        logic [NREQ-1:0] g;
        @(negedge clk);
        g = rq.reqValid & rq.reqReady;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (g[i]) orderQ.push_back(i);
        if (!keepValid) rq.reqValid = rq.reqValid & ~g;
    endtask

    task automatic raise(input int i, input logic [DWIDTH-1:0] d, input logic [CRC_GPW_MAX-1:0] p);
        rq.reqData[i*DWIDTH +: DWIDTH]           = d;
        rq.reqPoly[i*CRC_GPW_MAX +: CRC_GPW_MAX] = p;
        rq.reqValid[i]                           = 1'b1;
    endtask

    task automatic waitIdle(input int budget);
        for (int c = 0; c < budget && busy; c++) step();
        chk("returnIdle", 32'(busy), 32'(0));
    endtask

    task automatic waitRsp(input int budget);
        for (int c = 0; c < budget && !rq.rspValid; c++) step();
        chk("rspArrives", 32'(rq.rspValid), 32'(1));
    endtask

    initial begin
        int expOrd [6];
        expOrd = '{0, 1, 2, 3, 0, 1};
        rstN        = 1'b0;
        keepValid   = 1'b1;
        rq.reqValid = '0;
        rq.reqData  = '0;
        rq.reqPoly  = '0;
        rq.rspReady = 1'b1;
        raise(0, 16'hA522, 8'h07);
        raise(1, 16'hF0E5, 8'h1D);
        raise(2, 16'h0102, 8'hD5);
        raise(3, 16'h1234, 8'h07);
        repeat (3) step();
        chk("rstReqReady", 32'(rq.reqReady), 32'(0));
        chk("rstCtrlEn", 32'(ctrlEn), 32'(0));
        chk("rstRspValid", 32'(rq.rspValid), 32'(0));
        chk("rstBusy", 32'(busy), 32'(0));
        chk("rstRspFields", 32'({rq.rspId, rq.rspCrc, rq.rspErr}), 32'(0));
        chk("rstOperands", 32'({dataIn, GenPoly}), 32'(0));

        // Fairness: all four held valid continuously.
        orderQ.delete();
        rstN = 1'b1;
        for (int c = 0; c < 300 && orderQ.size() < 6; c++) step();
        chk("fairGrantCount", 32'(orderQ.size()), 32'(6));
        for (int k = 0; k < 6 && k < orderQ.size(); k++) chk("fairGrantOrder", 32'(orderQ[k]), 32'(expOrd[k]));
        keepValid   = 1'b0;
        rq.reqValid = '0;
        waitIdle(100);

        // Single request from requester 1.
        raise(1, 16'h0102, 8'h07);
        waitRsp(100);
        chk("singleId", 32'(rq.rspId), 32'(1));
        chk("singleCrc", 32'(rq.rspCrc), 32'(8'h1B));
        chk("singleErr", 32'(rq.rspErr), 32'(0));
        step();
        waitIdle(20);

        // Backpressure on the response port with another client waiting.
        rq.rspReady = 1'b0;
        raise(2, 16'($urandom), 8'($urandom));
        waitRsp(100);
        raise(3, 16'($urandom), 8'($urandom));
        for (int c = 0; c < 10; c++) begin
            step();
            chk("bpNoGrant", 32'(rq.reqReady), 32'(0));
            chk("bpNoStart", 32'(ctrlEn), 32'(0));
            chk("bpValid", 32'(rq.rspValid), 32'(1));
        end
        rq.rspReady = 1'b1;
        for (int c = 0; c < 20 && rq.reqValid[3]; c++) step();
        chk("bpNextGrant", 32'(rq.reqValid[3]), 32'(0));
        waitIdle(100);

        // Reset while waiting on the engine; the client re-presents its request.
        raise(0, 16'h5A3C, 8'h9B);
        for (int c = 0; c < 50 && !(busy && !crcReady); c++) step();
        step();
        rstN = 1'b0;
        step();
        step();
        chk("midRstBusy", 32'(busy), 32'(0));
        chk("midRstRspValid", 32'(rq.rspValid), 32'(0));
        chk("midRstCtrlEn", 32'(ctrlEn), 32'(0));
        chk("midRstOperands", 32'({dataIn, GenPoly, rq.rspCrc}), 32'(0));
        rq.reqValid[0] = 1'b1;
        rstN = 1'b1;
        waitRsp(100);
        chk("midRstRegrantId", 32'(rq.rspId), 32'(0));
        step();
        waitIdle(20);

        // Random traffic with random response backpressure and occasional withdrawn requests.
        for (int c = 0; c < 800; c++) begin
            rq.rspReady = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!rq.reqValid[i] && $urandom_range(0, 5) == 0) begin
                    raise(i, 16'($urandom), 8'($urandom));
                end else if (rq.reqValid[i] && !rq.reqReady[i] && $urandom_range(0, 40) == 0) begin
                    rq.reqValid[i] = 1'b0;
                end
            end
            step();
        end
        rq.rspReady = 1'b1;
        for (int c = 0; c < 600 && (busy || rq.reqValid != '0); c++) step();
        chk("drainDone", 32'({busy, rq.reqValid}), 32'(0));

`ifdef CRC_REQ_ARB_TIMEOUT_EN
        tbHang = 1'b1;
        rq.rspReady = 1'b0;
        raise(1, 16'hBEEF, 8'h31);
        waitRsp(TIMEOUT_CYC + 40);
        chk("toErr", 32'(rq.rspErr), 32'(1));
        chk("toCrc", 32'(rq.rspCrc), 32'(0));
        rq.rspReady = 1'b1;
        step();
        waitIdle(10);
        tbHang = 1'b0;
        repeat (5) step();
`endif

        repeat (4) step();
        chk("scoreboardEmpty", 32'(expQ.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", nChecks, nFail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/crc_req_arbiter.md
Name: crc_req_arbiter

Overview:
- Shares one crcParallel engine (16-bit data word, 8-bit generator polynomial) among NREQ requesters.
- Arbitrates requests round-robin and latches the winning word and polynomial.
- Sequences the engine: ctrlEn pulse, wait for crcReady to fall and then rise, capture crcSeq.
- Returns the CRC, tagged with the requester index, on a valid/ready response port. Sits between client blocks and the crcParallel instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DWIDTH, 16, data word width; matches the engine.
- CRC_GPW_MAX, 8, polynomial and CRC width; matches the engine.
- IDW, 2, requester index width; must satisfy 2**IDW >= NREQ.
- TIMEOUT_CYC, 64, max cycles waiting on the engine (only used with the optional feature).

Ports:
- clk  in  1  clock.
- rstN  in  1  reset, asynchronous assert, active low.
- reqValid  in  NREQ  per-requester request valid.
- reqData  in  NREQ*DWIDTH  flattened data words; requester i uses bits [i*DWIDTH +: DWIDTH].
- reqPoly  in  NREQ*CRC_GPW_MAX  flattened polynomials, same packing.
- reqReady  out  NREQ  one-hot accept; a request transfers when reqValid[i] & reqReady[i].
- ctrlEn  out  1  engine start pulse.
- dataIn  out  DWIDTH  engine data.
- GenPoly  out  CRC_GPW_MAX  engine polynomial.
- crcSeq  in  CRC_GPW_MAX  engine result.
- crcReady  in  1  engine ready; high when idle or done, low while busy.
- rspValid  out  1  response valid.
- rspReady  in  1  response accept.
- rspId  out  IDW  index of the requester that owns the response.
- rspCrc  out  CRC_GPW_MAX  CRC result.
- rspErr  out  1  engine timeout flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE, ctrlEn 0, dataIn 0, GenPoly 0, reqReady 0, rspValid 0, rspId 0, rspCrc 0, rspErr 0, busy 0, rrPtr NREQ-1 (so requester 0 wins first after reset).
- Reset mid-operation aborts everything immediately; an in-flight engine result is discarded.
- FSM is IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> RESP -> IDLE.
- IDLE:
  - If any reqValid is high, grant the first set index searching from rrPtr+1 upward with wrap-around.
  - reqReady is combinational: one-hot to the winner, only in IDLE. All zero otherwise.
  - On grant: register the winner's data into dataIn, its polynomial into GenPoly, its index into the id register; set rrPtr to the winner; go to ISSUE.
- ISSUE: ctrlEn=1 for exactly this one cycle; go to WAIT_BUSY.
- WAIT_BUSY: stay until crcReady==0, then go to WAIT_DONE. The engine guarantees at least one low cycle after ctrlEn.
- WAIT_DONE: on crcReady==1, capture crcSeq into rspCrc and go to RESP.
- RESP:
  - rspValid=1, with rspId, rspCrc and rspErr held stable until rspValid & rspReady.
  - On that handshake go to IDLE; rspValid drops the next cycle.
- dataIn and GenPoly hold their values from grant until the next grant and never change while the engine is busy.
- Latency: grant in cycle T; ctrlEn in T+1; rspValid in the cycle after crcReady is seen rising.
  - Minimum grant-to-grant spacing is 5 cycles with rspReady tied high.
- Requests arriving during non-IDLE states wait; reqValid must be held until reqReady. A requester that drops reqValid before grant is simply skipped.
- Simultaneous requests: round-robin order strictly from rrPtr+1, so no requester starves.
- With a single requester continuously valid, it is granted every round.

Optional Feature:
- Macro: CRC_REQ_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT_BUSY and increments in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYC-1, go to RESP with rspErr=1 and rspCrc=0.
  - rspErr=0 on normal completion.
- When undefined: no counter is built, WAIT states wait indefinitely, and rspErr is tied 0.

Test Plan:
- Reset: hold rstN=0 with reqValid=4'b1111 -> reqReady=0, ctrlEn=0, rspValid=0, busy=0. After release, requester 0 is granted first.
- Single request: req1 data 0x0102, poly 0x07 -> reqReady=4'b0010 for one cycle, one ctrlEn pulse with dataIn=0x0102 and GenPoly=0x07. Then rspValid with rspId=1, rspCrc=0x1B, rspErr=0.
- Fairness: all four valid continuously (data 0xA522, 0xF0E5, 0x0102, 0x1234; poly 0x07/0x1D/0xD5/0x07) -> grants 0,1,2,3,0,1 in order, each rspCrc matching the engine's result for that pair.
- Backpressure: hold rspReady=0 for 10 cycles during RESP -> rspValid, rspId and rspCrc stable, no new grant, no ctrlEn. Release -> IDLE, next grant follows.
- Reset mid-operation: assert rstN=0 in WAIT_DONE -> all outputs return to reset values. After release, the pending request is re-granted with no spurious rspValid.
- Timeout (CRC_REQ_ARB_TIMEOUT_EN defined, stub engine holding crcReady=0) -> after 64 cycles rspValid=1, rspErr=1, rspCrc=0x00, then IDLE.
